// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and data memory (slave).
// Request side is driven by the stage; ack/rdata return from memory.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [3:0]        dmem_be;
    logic              dmem_ack;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: req/ack data-memory handshake with timeout, load alignment and
// extension, MEM_WB pipeline register and pipeline-freeze generation.
module mem_access_stage #(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        dbg,
    input  logic        EX_MEM_memread,
    input  logic        EX_MEM_memwrite,
    input  logic        EX_MEM_regwrite,
    input  logic [4:0]  EX_MEM_rd,
    input  logic [31:0] EX_MEM_alures,
    input  logic [31:0] EX_MEM_dout_rs2,
    input  logic [4:0]  EX_MEM_loadcntrl,
    input  logic [2:0]  EX_MEM_storecntrl,
    mem_access_stage_if.master dmem,
    output logic        mem_hold,
    output logic        mem_fault,
    output logic        MEM_WB_regwrite,
    output logic [4:0]  MEM_WB_rd,
    output logic        MEM_WB_memread,
    output logic [31:0] MEM_WB_alures,
    output logic [31:0] MEM_WB_memres,
    output logic [31:0] WB_res
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [31:0] buf_r;
    logic        buf_valid_r;

    logic        mem_op_s;
    logic        byte_s;
    logic        half_s;
    logic        word_s;
    logic        aligned_s;
    logic        acc_s;
    logic        misalign_s;
    logic        ack_eff_s;
    logic [31:0] rdata_eff_s;
    logic        done_s;
    logic        timeout_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    // Select, then sign- or zero-extend the addressed byte/half of a read word.
    function automatic logic [31:0] load_align(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [4:0]  lc);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (lc)
            5'b00001: r = {{24{b[7]}}, b};
            5'b00010: r = {{16{h[15]}}, h};
            5'b00100: r = word;
            5'b01000: r = {24'h000000, b};
            5'b10000: r = {16'h0000, h};
            default:  r = 32'h00000000;
        endcase
        return r;
    endfunction

    // Access decode: size, alignment, lane enables and replicated store data.
    always_comb begin
        mem_op_s = EX_MEM_memread | EX_MEM_memwrite;
        byte_s   = EX_MEM_loadcntrl[0] | EX_MEM_loadcntrl[3] | EX_MEM_storecntrl[0];
        half_s   = EX_MEM_loadcntrl[1] | EX_MEM_loadcntrl[4] | EX_MEM_storecntrl[1];
        word_s   = EX_MEM_loadcntrl[2] | EX_MEM_storecntrl[2];
        if (word_s) begin
            aligned_s = (EX_MEM_alures[1:0] == 2'b00);
        end else if (half_s) begin
            aligned_s = ~EX_MEM_alures[0];
        end else begin
            aligned_s = 1'b1;
        end
        acc_s      = mem_op_s & aligned_s & ~dbg;
        misalign_s = mem_op_s & ~aligned_s & ~dbg;
        if (byte_s) begin
            be_s = 4'b0001 << EX_MEM_alures[1:0];
        end else if (half_s) begin
            be_s = EX_MEM_alures[1] ? 4'b1100 : 4'b0011;
        end else begin
            be_s = 4'b1111;
        end
        if (EX_MEM_storecntrl[0]) begin
            wdata_s = {4{EX_MEM_dout_rs2[7:0]}};
        end else if (EX_MEM_storecntrl[1]) begin
            wdata_s = {2{EX_MEM_dout_rs2[15:0]}};
        end else begin
            wdata_s = EX_MEM_dout_rs2;
        end
    end

    // Completion/timeout detection and the combinational hold/fault outputs.
    always_comb begin
        ack_eff_s   = dmem.dmem_ack | buf_valid_r;
        rdata_eff_s = buf_valid_r ? buf_r : dmem.dmem_rdata;
        done_s      = (state_r == ST_WAIT) & ack_eff_s & ~dbg;
        timeout_s   = (state_r == ST_WAIT) & ~ack_eff_s & ~dbg & (cnt_r == TMO_LAST);
        case (state_r)
            ST_IDLE: begin
                mem_hold  = acc_s & ~Rst;
                mem_fault = misalign_s & ~Rst;
            end
            ST_REQ: begin
                mem_hold  = ~Rst;
                mem_fault = 1'b0;
            end
            ST_WAIT: begin
                mem_hold  = ~(done_s | timeout_s) & ~Rst;
                mem_fault = timeout_s & ~Rst;
            end
            default: begin
                mem_hold  = 1'b0;
                mem_fault = 1'b0;
            end
        endcase
    end

    // Handshake FSM, timeout counter, debug ack buffer and MEM_WB register.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r          <= ST_IDLE;
            cnt_r            <= 8'd0;
            buf_r            <= 32'h00000000;
            buf_valid_r      <= 1'b0;
            dmem.dmem_req    <= 1'b0;
            dmem.dmem_we     <= 1'b0;
            dmem.dmem_addr   <= '0;
            dmem.dmem_wdata  <= 32'h00000000;
            dmem.dmem_be     <= 4'b0000;
            MEM_WB_regwrite  <= 1'b0;
            MEM_WB_rd        <= 5'd0;
            MEM_WB_memread   <= 1'b0;
            MEM_WB_alures    <= 32'h00000000;
            MEM_WB_memres    <= 32'h00000000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!dbg) begin
                        if (acc_s) begin
                            state_r         <= ST_REQ;
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= EX_MEM_memwrite;
                            dmem.dmem_addr  <= {EX_MEM_alures[ADDR_W-1:2], 2'b00};
                            dmem.dmem_wdata <= wdata_s;
                            dmem.dmem_be    <= be_s;
                        end else begin
                            // Non-memory ops and misaligned accesses retire here.
                            MEM_WB_regwrite <= EX_MEM_regwrite & ~misalign_s;
                            MEM_WB_rd       <= EX_MEM_rd;
                            MEM_WB_memread  <= EX_MEM_memread;
                            MEM_WB_alures   <= EX_MEM_alures;
                            MEM_WB_memres   <= 32'h00000000;
                        end
                    end
                end
                ST_REQ: begin
                    if (!dbg) begin
                        state_r       <= ST_WAIT;
                        dmem.dmem_req <= 1'b0;
                        cnt_r         <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (dbg) begin
                        // Ack under debug freeze is parked until the freeze lifts.
                        if (dmem.dmem_ack && !buf_valid_r) begin
                            buf_r       <= dmem.dmem_rdata;
                            buf_valid_r <= 1'b1;
                        end
                    end else if (ack_eff_s) begin
                        state_r         <= ST_IDLE;
                        buf_valid_r     <= 1'b0;
                        MEM_WB_regwrite <= EX_MEM_regwrite;
                        MEM_WB_rd       <= EX_MEM_rd;
                        MEM_WB_memread  <= EX_MEM_memread;
                        MEM_WB_alures   <= EX_MEM_alures;
                        MEM_WB_memres   <= load_align(rdata_eff_s, EX_MEM_alures[1:0],
                                                      EX_MEM_loadcntrl);
                    end else if (cnt_r == TMO_LAST) begin
                        state_r         <= ST_IDLE;
                        MEM_WB_regwrite <= 1'b0;
                        MEM_WB_rd       <= EX_MEM_rd;
                        MEM_WB_memread  <= EX_MEM_memread;
                        MEM_WB_alures   <= EX_MEM_alures;
                        MEM_WB_memres   <= 32'h00000000;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign WB_res = MEM_WB_memread ? MEM_WB_memres : MEM_WB_alures;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage: loads, stores, misalignment,
// timeout, reset mid-access and debug-freeze ack buffering.
module tb_mem_access_stage;

    logic        clk;
    logic        Rst;
    logic        dbg;
    logic        EX_MEM_memread;
    logic        EX_MEM_memwrite;
    logic        EX_MEM_regwrite;
    logic [4:0]  EX_MEM_rd;
    logic [31:0] EX_MEM_alures;
    logic [31:0] EX_MEM_dout_rs2;
    logic [4:0]  EX_MEM_loadcntrl;
    logic [2:0]  EX_MEM_storecntrl;
    logic        mem_hold;
    logic        mem_fault;
    logic        MEM_WB_regwrite;
    logic [4:0]  MEM_WB_rd;
    logic        MEM_WB_memread;
    logic [31:0] MEM_WB_alures;
    logic [31:0] MEM_WB_memres;
    logic [31:0] WB_res;

    mem_access_stage_if #(.ADDR_W(32)) dmem_bus ();

    mem_access_stage #(.TIMEOUT(255), .ADDR_W(32)) dut (
        .clk               (clk),
        .Rst               (Rst),
        .dbg               (dbg),
        .EX_MEM_memread    (EX_MEM_memread),
        .EX_MEM_memwrite   (EX_MEM_memwrite),
        .EX_MEM_regwrite   (EX_MEM_regwrite),
        .EX_MEM_rd         (EX_MEM_rd),
        .EX_MEM_alures     (EX_MEM_alures),
        .EX_MEM_dout_rs2   (EX_MEM_dout_rs2),
        .EX_MEM_loadcntrl  (EX_MEM_loadcntrl),
        .EX_MEM_storecntrl (EX_MEM_storecntrl),
        .dmem              (dmem_bus.master),
        .mem_hold          (mem_hold),
        .mem_fault         (mem_fault),
        .MEM_WB_regwrite   (MEM_WB_regwrite),
        .MEM_WB_rd         (MEM_WB_rd),
        .MEM_WB_memread    (MEM_WB_memread),
        .MEM_WB_alures     (MEM_WB_alures),
        .MEM_WB_memres     (MEM_WB_memres),
        .WB_res            (WB_res)
    );

    int          n_checks;
    int          n_fail;
    int          hold_n;
    int          fault_at;
    logic        hold_at_fault;
    logic        req_seen;
    logic        we_seen;
    logic [31:0] addr_seen;
    logic [31:0] wdata_seen;
    logic [3:0]  be_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        #1;
        hold_n += int'(mem_hold);
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop(input logic rw, input logic [31:0] res);
        EX_MEM_memread    = 1'b0;
        EX_MEM_memwrite   = 1'b0;
        EX_MEM_regwrite   = rw;
        EX_MEM_rd         = 5'd0;
        EX_MEM_alures     = res;
        EX_MEM_dout_rs2   = 32'h00000000;
        EX_MEM_loadcntrl  = 5'b00000;
        EX_MEM_storecntrl = 3'b000;
    endtask

    task automatic set_op(input logic rd_op, input logic wr_op, input logic rw, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [4:0] lc, input logic [2:0] sc);
        EX_MEM_memread    = rd_op;
        EX_MEM_memwrite   = wr_op;
        EX_MEM_regwrite   = rw;
        EX_MEM_rd         = rd;
        EX_MEM_alures     = addr;
        EX_MEM_dout_rs2   = rs2;
        EX_MEM_loadcntrl  = lc;
        EX_MEM_storecntrl = sc;
    endtask

    // Access already driven on EX_MEM; ack returned after wait_n idle WAIT cycles.
    task automatic run_access(input logic [31:0] rdata, input int wait_n);
        hold_n = 0;
        step();
        req_seen   = dmem_bus.dmem_req;
        we_seen    = dmem_bus.dmem_we;
        addr_seen  = dmem_bus.dmem_addr;
        wdata_seen = dmem_bus.dmem_wdata;
        be_seen    = dmem_bus.dmem_be;
        step();
        repeat (wait_n) step();
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = rdata;
        step();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h00000000;
        set_nop(1'b0, 32'h00000000);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hold_n   = 0;
        Rst      = 1'b1;
        dbg      = 1'b0;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h00000000;
        set_nop(1'b0, 32'h00000000);
        step();
        step();
        check_val("rst_req",  {31'd0, dmem_bus.dmem_req}, 32'd0);
        check_val("rst_hold", {31'd0, mem_hold}, 32'd0);
        check_val("rst_rw",   {31'd0, MEM_WB_regwrite}, 32'd0);
        check_val("rst_wb",   WB_res, 32'h00000000);
        Rst = 1'b0;

        // Non-memory op passes straight through.
        set_nop(1'b1, 32'h11223344);
        EX_MEM_rd = 5'd5;
        step();
        check_val("nop_rw", {31'd0, MEM_WB_regwrite}, 32'd1);
        check_val("nop_rd", {27'd0, MEM_WB_rd}, 32'd5);
        check_val("nop_wb", WB_res, 32'h11223344);

        // LW 0x100, two empty WAIT cycles before ack.
        set_op(1'b1, 1'b0, 1'b1, 5'd7, 32'h00000100, 32'h0, 5'b00100, 3'b000);
        run_access(32'hDEADBEEF, 2);
        check_val("lw_req",   {31'd0, req_seen}, 32'd1);
        check_val("lw_addr",  addr_seen, 32'h00000100);
        check_val("lw_hold",  hold_n, 32'd4);
        check_val("lw_res",   MEM_WB_memres, 32'hDEADBEEF);
        check_val("lw_rw",    {31'd0, MEM_WB_regwrite}, 32'd1);
        check_val("lw_rd",    {27'd0, MEM_WB_rd}, 32'd7);
        check_val("lw_wb",    WB_res, 32'hDEADBEEF);
        check_val("lw_rqoff", {31'd0, dmem_bus.dmem_req}, 32'd0);

        set_op(1'b1, 1'b0, 1'b1, 5'd8, 32'h00000103, 32'h0, 5'b00001, 3'b000);
        run_access(32'h80123456, 0);
        check_val("lb_res", MEM_WB_memres, 32'hFFFFFF80);
        check_val("lb_be",  {28'd0, be_seen}, 32'h8);

        set_op(1'b1, 1'b0, 1'b1, 5'd8, 32'h00000103, 32'h0, 5'b01000, 3'b000);
        run_access(32'h80123456, 1);
        check_val("lbu_res", MEM_WB_memres, 32'h00000080);

        set_op(1'b1, 1'b0, 1'b1, 5'd9, 32'h00000102, 32'h0, 5'b00010, 3'b000);
        run_access(32'h80017777, 0);
        check_val("lh_res", MEM_WB_memres, 32'hFFFF8001);

        set_op(1'b1, 1'b0, 1'b1, 5'd9, 32'h00000100, 32'h0, 5'b10000, 3'b000);
        run_access(32'h1234F00D, 0);
        check_val("lhu_res", MEM_WB_memres, 32'h0000F00D);

        // Stores: lane enables and replicated data.
        set_op(1'b0, 1'b1, 1'b0, 5'd0, 32'h00000102, 32'h1234ABCD, 5'b00000, 3'b010);
        run_access(32'h00000000, 0);
        check_val("sh_be",    {28'd0, be_seen}, 32'hC);
        check_val("sh_wdata", wdata_seen, 32'hABCDABCD);
        check_val("sh_we",    {31'd0, we_seen}, 32'd1);
        check_val("sh_addr",  addr_seen, 32'h00000100);
        check_val("sh_rw",    {31'd0, MEM_WB_regwrite}, 32'd0);

        set_op(1'b0, 1'b1, 1'b0, 5'd0, 32'h00000101, 32'h000000EF, 5'b00000, 3'b001);
        run_access(32'h00000000, 0);
        check_val("sb_be",    {28'd0, be_seen}, 32'h2);
        check_val("sb_wdata", wdata_seen, 32'hEFEFEFEF);

        // Misaligned LW: fault for one cycle, no request, retires without write.
        set_nop(1'b1, 32'h00000042);
        step();
        set_op(1'b1, 1'b0, 1'b1, 5'd3, 32'h00000101, 32'h0, 5'b00100, 3'b000);
        #1;
        check_val("mis_fault", {31'd0, mem_fault}, 32'd1);
        check_val("mis_hold",  {31'd0, mem_hold}, 32'd0);
        step();
        check_val("mis_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        check_val("mis_rw",  {31'd0, MEM_WB_regwrite}, 32'd0);
        set_nop(1'b0, 32'h00000000);
        #1;
        check_val("mis_fclr", {31'd0, mem_fault}, 32'd0);

        // Timeout: no ack ever returned.
        set_nop(1'b1, 32'h00000042);
        step();
        set_op(1'b1, 1'b0, 1'b1, 5'd4, 32'h00000200, 32'h0, 5'b00100, 3'b000);
        step();
        step();
        fault_at      = 0;
        hold_at_fault = 1'b1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (mem_fault) begin
                fault_at      = i + 1;
                hold_at_fault = mem_hold;
                break;
            end
            @(posedge clk);
        end
        check_val("tmo_cycles", fault_at, 32'd255);
        check_val("tmo_hold",   {31'd0, hold_at_fault}, 32'd0);
        @(posedge clk);
        #1;
        set_nop(1'b0, 32'h00000000);
        check_val("tmo_rw",  {31'd0, MEM_WB_regwrite}, 32'd0);
        check_val("tmo_res", MEM_WB_memres, 32'h00000000);
        #1;
        check_val("tmo_idle", {31'd0, mem_hold}, 32'd0);

        // Reset during WAIT; a later ack must have no effect.
        set_nop(1'b1, 32'h00000055);
        step();
        check_val("pre_rst_wb", WB_res, 32'h00000055);
        set_op(1'b1, 1'b0, 1'b1, 5'd6, 32'h00000300, 32'h0, 5'b00100, 3'b000);
        step();
        step();
        step();
        Rst = 1'b1;
        step();
        #1;
        check_val("rst_mid_hold", {31'd0, mem_hold}, 32'd0);
        check_val("rst_mid_req",  {31'd0, dmem_bus.dmem_req}, 32'd0);
        check_val("rst_mid_wb",   WB_res, 32'h00000000);
        Rst = 1'b0;
        set_nop(1'b0, 32'h00000000);
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'hCAFEF00D;
        step();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h00000000;
        check_val("rst_ack_res", MEM_WB_memres, 32'h00000000);
        check_val("rst_ack_rw",  {31'd0, MEM_WB_regwrite}, 32'd0);
        check_val("rst_ack_req", {31'd0, dmem_bus.dmem_req}, 32'd0);

        // Debug freeze during WAIT: ack buffered, committed when dbg drops.
        set_op(1'b1, 1'b0, 1'b1, 5'd9, 32'h00000400, 32'h0, 5'b00100, 3'b000);
        step();
        step();
        dbg = 1'b1;
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h0BADF00D;
        step();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h00000000;
        step();
        #1;
        check_val("dbg_hold",   {31'd0, mem_hold}, 32'd1);
        check_val("dbg_frozen", {31'd0, MEM_WB_regwrite}, 32'd0);
        dbg = 1'b0;
        #1;
        check_val("dbg_release", {31'd0, mem_hold}, 32'd0);
        step();
        set_nop(1'b0, 32'h00000000);
        check_val("dbg_res", MEM_WB_memres, 32'h0BADF00D);
        check_val("dbg_rw",  {31'd0, MEM_WB_regwrite}, 32'd1);
        check_val("dbg_rd",  {27'd0, MEM_WB_rd}, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
